// File: rtl/hazard_unit_mc_pkg.sv
// Shared types and helpers for the multi-core hazard/stall controller.
package hazard_unit_mc_pkg;

    // Widest register address / mem_to_reg select the detect helper accepts.
    localparam int LU_ADDR_W = 16;
    localparam int LU_SEL_W  = 8;

    // Load-use window states: IDLE means lu_cnt==0, HOLD means lu_cnt!=0.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic fetch;
        logic decode;
        logic execute;
        logic mem;
        logic flush;
    } stall_vec_t;

    // Width of the per-core load-use counter for a given latency.
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

    // Width of the arbiter pointer; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A load in EX whose non-zero destination feeds either ID source register.
    function automatic logic lu_detect(
        input logic [LU_SEL_W-1:0]  m2r,
        input logic [LU_ADDR_W-1:0] wr,
        input logic [LU_ADDR_W-1:0] rs,
        input logic [LU_ADDR_W-1:0] rt
    );
        return (m2r != '0) && (wr != '0) && ((rs == wr) || (rt == wr));
    endfunction

endpackage

// File: rtl/hazard_unit_mc_rr_arbiter.sv
// Round-robin arbiter for the shared data-memory port: one-hot (or zero) grant,
// search starts at rr_ptr and the pointer moves just past the winner.
module hazard_unit_mc_rr_arbiter
    import hazard_unit_mc_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PTR_W = ptr_width(N);

    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic [2*N-1:0]   req_dbl_s;
    logic [N-1:0]     req_rot_s;
    logic [N-1:0]     hot_rot_s;
    logic [2*N-1:0]   hot_dbl_s;
    logic             found_s;
    int               off_s;
    int               win_s;

    // Rotate requests so bit 0 is the core at rr_ptr, pick the lowest set bit,
    // rotate the one-hot back and derive the next pointer from the winner.
    always_comb begin
        req_dbl_s = {req, req} >> rr_ptr_r;
        req_rot_s = req_dbl_s[N-1:0];
        hot_rot_s = '0;
        found_s   = 1'b0;
        off_s     = 0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && req_rot_s[i]) begin
                hot_rot_s[i] = 1'b1;
                found_s      = 1'b1;
                off_s        = i;
            end else begin
                hot_rot_s[i] = hot_rot_s[i];
            end
        end
        hot_dbl_s = {{N{1'b0}}, hot_rot_s} << rr_ptr_r;
        win_s     = int'(rr_ptr_r) + off_s;
        if (win_s >= N) begin
            win_s = win_s - N;
        end else begin
            win_s = win_s;
        end
        if (reset) begin
            grant     = '0;
            ptr_nxt_s = '0;
        end else if (found_s) begin
            grant     = hot_dbl_s[N-1:0] | hot_dbl_s[2*N-1:N];
            ptr_nxt_s = (win_s == N - 1) ? '0 : PTR_W'(win_s + 1);
        end else begin
            grant     = '0;
            ptr_nxt_s = rr_ptr_r;
        end
    end

    // Pointer register; cleared by reset, otherwise follows the last winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else begin
            rr_ptr_r <= ptr_nxt_s;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Per-core hazard/stall controller: core freeze, shared-memory arbitration loss
// and load-use stalls with a configurable load-to-use latency.
module hazard_unit_mc
    import hazard_unit_mc_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int REG_ADDR_W = 5,
    parameter int MEM2REG_W  = 2,
    parameter int LOAD_LAT   = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            core_en,
    input  logic [NUM_CORES*REG_ADDR_W-1:0] wr_addr_ex,
    input  logic [NUM_CORES*MEM2REG_W-1:0]  mem_to_reg_ex,
    input  logic [NUM_CORES*REG_ADDR_W-1:0] rs_id,
    input  logic [NUM_CORES*REG_ADDR_W-1:0] rt_id,
    input  logic [NUM_CORES-1:0]            mem_req,
    output logic [NUM_CORES-1:0]            mem_grant,
    output logic [NUM_CORES-1:0]            stall_fetch,
    output logic [NUM_CORES-1:0]            stall_decode,
    output logic [NUM_CORES-1:0]            stall_execute,
    output logic [NUM_CORES-1:0]            stall_mem,
    output logic [NUM_CORES-1:0]            flush_ex
);

    localparam int CNT_W = cnt_width(LOAD_LAT);

    logic [NUM_CORES-1:0] arb_req_s;
    logic [NUM_CORES-1:0] grant_s;

    // Frozen cores never compete for the memory port.
    assign arb_req_s = mem_req & core_en;
    assign mem_grant = grant_s;

    hazard_unit_mc_rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (arb_req_s),
        .grant (grant_s)
    );

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        logic [CNT_W-1:0] lu_cnt_r;
        logic [CNT_W-1:0] lu_cnt_nxt_s;
        logic             detect_s;
        logic [0:0]       state_s;
        stall_vec_t       sv_s;

        assign detect_s = lu_detect(
            LU_SEL_W'(mem_to_reg_ex[i*MEM2REG_W +: MEM2REG_W]),
            LU_ADDR_W'(wr_addr_ex[i*REG_ADDR_W +: REG_ADDR_W]),
            LU_ADDR_W'(rs_id[i*REG_ADDR_W +: REG_ADDR_W]),
            LU_ADDR_W'(rt_id[i*REG_ADDR_W +: REG_ADDR_W])
        );

        assign state_s = (lu_cnt_r != '0) ? ST_HOLD : ST_IDLE;

        // Priority resolve: reset, freeze, arbitration loss, load-use, run.
        // Frozen cycles leave the counter alone so they stretch the window.
        always_comb begin
            sv_s         = '0;
            lu_cnt_nxt_s = lu_cnt_r;
            if (reset) begin
                lu_cnt_nxt_s = '0;
            end else if (!core_en[i]) begin
                sv_s = '{fetch: 1'b1, decode: 1'b1, execute: 1'b1, mem: 1'b1, flush: 1'b0};
            end else if (mem_req[i] && !grant_s[i]) begin
                sv_s = '{fetch: 1'b1, decode: 1'b1, execute: 1'b1, mem: 1'b1, flush: 1'b0};
            end else if (detect_s || (state_s == ST_HOLD)) begin
                sv_s = '{fetch: 1'b1, decode: 1'b1, execute: 1'b0, mem: 1'b0, flush: 1'b1};
                case (state_s)
                    ST_IDLE: lu_cnt_nxt_s = CNT_W'(LOAD_LAT - 1);
                    ST_HOLD: lu_cnt_nxt_s = lu_cnt_r - CNT_W'(1);
                    default: lu_cnt_nxt_s = '0;
                endcase
            end else begin
                lu_cnt_nxt_s = lu_cnt_r;
            end
        end

        // Load-use window counter.
        always_ff @(posedge clk) begin
            if (reset) begin
                lu_cnt_r <= '0;
            end else begin
                lu_cnt_r <= lu_cnt_nxt_s;
            end
        end

        assign stall_fetch[i]   = sv_s.fetch;
        assign stall_decode[i]  = sv_s.decode;
        assign stall_execute[i] = sv_s.execute;
        assign stall_mem[i]     = sv_s.mem;
        assign flush_ex[i]      = sv_s.flush;
    end

endmodule
